saida_bcd: RTL and testbench



---
 rtl/saida_bcd.sv | 195 +++++++++++++++++++
 tb/tb_saida_bcd.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/saida_bcd.sv
// Display stage: captures the write-back value on `out`, converts it to BCD with a
// serial double-dabble engine and drives four active-low 7-segment displays.
// Optional signed display is enabled by defining SAIDA_NEGATIVE_SIGN_EN.
module saida_bcd #(
    parameter int CONV_BITS = 14
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        out,
    input  logic [31:0] valorsaida,
    output logic [3:0]  milhares,
    output logic [3:0]  centenas,
    output logic [3:0]  dezenas,
    output logic [3:0]  unidades,
    output logic [6:0]  d1,
    output logic [6:0]  d2,
    output logic [6:0]  d3,
    output logic [6:0]  d4,
    output logic        busy,
    output logic        done
);

    localparam int                CNT_W     = $clog2(CONV_BITS + 1);
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(CONV_BITS - 1);
    localparam logic [6:0]        SEG_DASH  = 7'b0111111;
    localparam logic [6:0]        SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   pend_q, pend_d;
    logic [31:0]            pend_val_q, pend_val_d;
    logic [CNT_W-1:0]       step_q, step_d;
    logic [15:0]            bcd_q, bcd_d;
    logic [CONV_BITS-1:0]   bin_q, bin_d;
    logic                   ovf_q, ovf_d;
    logic                   neg_q, neg_d;
    logic [15:0]            dig_q, dig_d;
    logic [27:0]            seg_q, seg_d;
    logic                   done_q, done_d;
    logic                   start;
    logic [31:0]            start_val;
    logic [CONV_BITS+1:0]   start_cls;

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_DASH;
        endcase
    endfunction

    function automatic logic [15:0] add3(input logic [15:0] bcd);
        logic [15:0] r;
        r = bcd;
        for (int i = 0; i < 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Returns {overflow, negative, low CONV_BITS of magnitude}.
    function automatic logic [CONV_BITS+1:0] classify(input logic [31:0] v);
        logic        neg;
        logic        ovf;
        logic [31:0] mag;
`ifdef SAIDA_NEGATIVE_SIGN_EN
        neg = v[31];
        mag = neg ? (32'd0 - v) : v;
        ovf = neg ? (mag > 32'd999) : (mag > 32'd9999);
`else
        neg = 1'b0;
        mag = v;
        ovf = (mag > 32'd9999);
`endif
        return {ovf, neg, mag[CONV_BITS-1:0]};
    endfunction

    // A strobe in DONE is newer than anything pending, so it wins.
    always_comb begin
        start     = 1'b0;
        start_val = valorsaida;
        case (state_q)
            IDLE: start = out;
            DONE: begin
                start     = out | pend_q;
                start_val = out ? valorsaida : pend_val_q;
            end
            default: ;
        endcase
        start_cls = classify(start_val);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            dig_q   <= 16'h0000;
            seg_q   <= {4{SEG_ZERO}};
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            dig_q   <= dig_d;
            seg_q   <= seg_d;
        end
    end

    always_ff @(posedge clock) begin
        pend_val_q <= pend_val_d;
        step_q     <= step_d;
        bcd_q      <= bcd_d;
        bin_q      <= bin_d;
        ovf_q      <= ovf_d;
        neg_q      <= neg_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CONV;
            CONV:    if (step_q == LAST_STEP) state_d = DONE;
            DONE:    state_d = start ? CONV : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        done     = done_q;
        milhares = dig_q[15:12];
        centenas = dig_q[11:8];
        dezenas  = dig_q[7:4];
        unidades = dig_q[3:0];
        d1       = seg_q[27:21];
        d2       = seg_q[20:14];
        d3       = seg_q[13:7];
        d4       = seg_q[6:0];
    end

    always_comb begin
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        step_d     = step_q;
        bcd_d      = bcd_q;
        bin_d      = bin_q;
        ovf_d      = ovf_q;
        neg_d      = neg_q;
        dig_d      = dig_q;
        seg_d      = seg_q;
        done_d     = 1'b0;

        if (start) begin
            ovf_d  = start_cls[CONV_BITS+1];
            neg_d  = start_cls[CONV_BITS];
            bin_d  = start_cls[CONV_BITS-1:0];
            bcd_d  = 16'h0000;
            step_d = '0;
        end else if (state_q == CONV) begin
            {bcd_d, bin_d} = {add3(bcd_q), bin_q} << 1;
            step_d         = step_q + 1'b1;
        end

        if (state_q == CONV && out) begin
            pend_d     = 1'b1;
            pend_val_d = valorsaida;
        end else if (state_q == DONE) begin
            pend_d = 1'b0;
        end

        if (state_q == DONE) begin
            done_d = 1'b1;
            if (ovf_q) begin
                dig_d = 16'hFFFF;
                seg_d = {4{SEG_DASH}};
            end else if (neg_q) begin
                dig_d = {4'hA, bcd_q[11:0]};
                seg_d = {SEG_DASH, seg7(bcd_q[11:8]), seg7(bcd_q[7:4]), seg7(bcd_q[3:0])};
            end else begin
                dig_d = bcd_q;
                seg_d = {seg7(bcd_q[15:12]), seg7(bcd_q[11:8]), seg7(bcd_q[7:4]), seg7(bcd_q[3:0])};
            end
        end
    end

endmodule

// File: tb/tb_saida_bcd.sv
// Bench for saida_bcd: directed and random strobes, an edge-level job model feeding
// a scoreboard, and a monitor that checks every done pulse against it.
module tb_saida_bcd;

    localparam int CB = 14;
    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] SEGS [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                         7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                         7'b0000000, 7'b0010000};

    logic        clock = 1'b0;
    logic        reset;
    logic        out;
    logic [31:0] valorsaida;
    logic [3:0]  milhares, centenas, dezenas, unidades;
    logic [6:0]  d1, d2, d3, d4;
    logic        busy, done;

    saida_bcd #(.CONV_BITS(CB)) dut (
        .clock(clock), .reset(reset), .out(out), .valorsaida(valorsaida),
        .milhares(milhares), .centenas(centenas), .dezenas(dezenas), .unidades(unidades),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] v;
        int          edge_n;
    } job_t;
    job_t sb[$];

    int checks = 0;
    int passes = 0;

    // Job model state: is a job in flight, at which edge does it finish, pending slot.
    bit          job_act = 0;
    int          done_edge = 0;
    bit          pend = 0;
    logic [31:0] pend_v = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Expected {digits[15:0], segments[27:0]} from the display rules.
    function automatic logic [43:0] expect_disp(input logic [31:0] v);
        logic        neg;
        logic [31:0] mag;
        int          m, th, h, t, u;
`ifdef SAIDA_NEGATIVE_SIGN_EN
        neg = v[31];
        mag = neg ? (~v + 32'd1) : v;
`else
        neg = 1'b0;
        mag = v;
`endif
        if ((!neg && mag > 32'd9999) || (neg && mag > 32'd999))
            return {16'hFFFF, DASH, DASH, DASH, DASH};
        m  = int'(mag);
        th = m / 1000;
        h  = (m / 100) % 10;
        t  = (m / 10) % 10;
        u  = m % 10;
        if (neg)
            return {4'hA, 4'(h), 4'(t), 4'(u), DASH, SEGS[h], SEGS[t], SEGS[u]};
        return {4'(th), 4'(h), 4'(t), 4'(u), SEGS[th], SEGS[h], SEGS[t], SEGS[u]};
    endfunction

    task automatic start_job(input int e, input logic [31:0] v);
        job_t j;
        job_act   = 1;
        done_edge = e + CB + 1;
        j.v       = v;
        j.edge_n  = done_edge;
        sb.push_back(j);
    endtask

    task automatic model_edge(input int e, input bit o, input logic [31:0] v);
        if (!job_act) begin
            if (o) start_job(e, v);
        end else if (e < done_edge) begin
            if (o) begin
                pend   = 1;
                pend_v = v;
            end
        end else begin
            job_act = 0;
            if (o) start_job(e, v);
            else if (pend) start_job(e, pend_v);
            pend = 0;
        end
    endtask

    task automatic drive(input bit o, input logic [31:0] v);
        @(negedge clock);
        if (!reset) check("busy", busy, job_act);
        out        = o;
        valorsaida = v;
        model_edge(cyc + 1, o, v);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, $urandom);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_digits"}, {milhares, centenas, dezenas, unidades}, 16'h0000);
        check({tag, "_segs"}, {d1, d2, d3, d4}, {4{7'b1000000}});
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding job, on its edge.
    initial begin
        job_t       j;
        logic [43:0] e;
        forever begin
            @(negedge clock);
            if (reset) continue;
            if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", done, 1'b0);
                end else begin
                    j = sb.pop_front();
                    e = expect_disp(j.v);
                    check("done_edge", cyc, j.edge_n);
                    check("digits", {milhares, centenas, dezenas, unidades}, e[43:28]);
                    check("segs", {d1, d2, d3, d4}, e[27:0]);
                end
            end else if (sb.size() > 0 && cyc > sb[0].edge_n) begin
                check("done_missing", cyc, sb[0].edge_n);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        reset      = 1'b1;
        out        = 1'b0;
        valorsaida = 32'd0;
        repeat (3) @(negedge clock);
        reset_checks("rst_init");
        reset = 1'b0;
        idle(2);

        drive(1, 32'd1234);  idle(17);
        drive(1, 32'd9999);  idle(17);
        drive(1, 32'd10000); idle(17);
        drive(1, 32'd0);     idle(17);

        // newest pending wins: 42 then 5, 7 is overwritten
        drive(1, 32'd42); idle(2); drive(1, 32'd7); idle(1); drive(1, 32'd5); idle(35);

        // strobe on the DONE edge
        drive(1, 32'd300); idle(14); drive(1, 32'd77); idle(20);

        drive(1, 32'hFFFFFFFB); idle(17);
        drive(1, 32'hFFFFFC18); idle(17);
        drive(1, 32'hFFFFFC19); idle(17);
        drive(1, 32'h80000000); idle(17);

        // asynchronous reset mid-conversion
        drive(1, 32'd8765); idle(6);
        @(posedge clock);
        #2 reset = 1'b1;
        #1 reset_checks("rst_conv");
        sb.delete();
        job_act = 0;
        pend    = 0;
        @(negedge clock);
        reset = 1'b0;
        idle(3);
        reset_checks("rst_after");

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 4))
                0:       v = $urandom_range(0, 9999);
                1:       v = $urandom_range(9990, 10010);
                2:       v = 32'd0 - $urandom_range(0, 1100);
                3:       v = $urandom;
                default: v = $urandom_range(0, 99);
            endcase
            drive(($urandom_range(0, 3) == 0), v);
        end
        idle(45);
        check("sb_drain", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
